// File: rtl/rnn_seq_driver.sv
// rtl/rnn_seq_driver.sv - token sequencer and bus master for the RNN accelerator slave (optional POLL_TIMEOUT_EN)
module rnn_seq_driver #(
    parameter int TOK_BITS    = 6,
    parameter int EMB_BITS    = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                emb_write,
    input  logic [TOK_BITS-1:0] emb_tok,
    input  logic [EMB_BITS-1:0] emb_idx,
    input  logic [15:0]         emb_data,
    output logic                emb_drop,
    input  logic                tok_valid,
    output logic                tok_ready,
    input  logic [TOK_BITS-1:0] tok_data,
    input  logic                tok_last,
    output logic                m_read,
    output logic                m_write,
    output logic [2:0]          m_addr,
    output logic [31:0]         m_wdata,
    input  logic [31:0]         m_rdata,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [15:0]         res_data,
    output logic                res_pos,
    output logic                res_err,
    output logic                busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_POLLS = 3'd3;
    localparam logic [2:0] S_DENSE = 3'd4;
    localparam logic [2:0] S_POLLV = 3'd5;
    localparam logic [2:0] S_RES   = 3'd6;
    localparam logic [2:0] S_OUT   = 3'd7;

    localparam int TBL_DEPTH = 1 << (TOK_BITS + EMB_BITS);

    logic [2:0]          state;
    logic [TOK_BITS-1:0] tok_q;
    logic                last_q;
    logic [EMB_BITS-1:0] idx_q;
    logic [15:0]         step_cnt;
    logic                run_en;
    logic                poll_to;
    logic [15:0]         emb_rd;
    logic [15:0]         emb_mem [0:TBL_DEPTH-1];
    logic                unused_rdata;

    assign unused_rdata = &{1'b0, m_rdata[31:16]};

    // Outside of a sequence the driver sits in IDLE with step_cnt at zero; a
    // non-zero step_cnt in IDLE means we are between tokens of one sequence.
    assign tok_ready = run_en && (state == S_IDLE);
    assign busy      = (state != S_IDLE) || (step_cnt != 16'd0);
    assign res_valid = (state == S_OUT);
    assign emb_rd    = emb_mem[{tok_q, idx_q}];

    // Embedding table: writable only while fully idle, never reset.
    always_ff @(posedge clk) begin
        if (emb_write && !busy) begin
            emb_mem[{emb_tok, emb_idx}] <= emb_data;
        end
    end

    // Bus strobes are decoded from the state so address/data are 0 off-strobe.
    always_comb begin
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = 3'd0;
        m_wdata = 32'd0;
        case (state)
            S_LOAD: begin
                m_write = 1'b1;
                m_addr  = 3'd1;
                m_wdata = {8'h00, 8'(idx_q), emb_rd};
            end
            S_START: begin
                m_write = 1'b1;
                m_addr  = 3'd0;
            end
            S_POLLS: begin
                m_read = 1'b1;
                m_addr = 3'd1;
            end
            S_DENSE: begin
                m_write = 1'b1;
                m_addr  = 3'd7;
            end
            S_POLLV: begin
                m_read = 1'b1;
                m_addr = 3'd0;
            end
            S_RES: begin
                m_read = 1'b1;
                m_addr = 3'd7;
            end
            default: ;
        endcase
    end

`ifdef POLL_TIMEOUT_EN
    logic [31:0] poll_cnt;

    assign poll_to = (poll_cnt == 32'(TIMEOUT_CYC - 1));

    // Poll cycle counter, zero on the first cycle of every polling phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= 32'd0;
        end else if (state == S_POLLS || state == S_POLLV) begin
            poll_cnt <= poll_cnt + 32'd1;
        end else begin
            poll_cnt <= 32'd0;
        end
    end

    // Timeout flag, held through the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err <= 1'b0;
        end else if ((state == S_POLLS || state == S_POLLV) && !m_rdata[0] && poll_to) begin
            res_err <= 1'b1;
        end else if (state == S_OUT && res_ready) begin
            res_err <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYC;

    assign poll_to = 1'b0;
    assign res_err = 1'b0;
`endif

    // Main sequencer: token accept, embedding load, step/dense polling, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tok_q    <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            step_cnt <= 16'd0;
            run_en   <= 1'b0;
            res_data <= 16'd0;
            res_pos  <= 1'b0;
            emb_drop <= 1'b0;
        end else begin
            run_en   <= 1'b1;
            emb_drop <= emb_write && busy;
            case (state)
                S_IDLE: begin
                    if (tok_valid && tok_ready) begin
                        tok_q  <= tok_data;
                        last_q <= tok_last;
                        idx_q  <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    idx_q <= idx_q + 1'b1;
                    if (&idx_q) begin
                        state <= S_START;
                    end
                end
                S_START: state <= S_POLLS;
                S_POLLS: begin
                    if (m_rdata[0]) begin
                        if (step_cnt != 16'hFFFF) begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                        state <= last_q ? S_DENSE : S_IDLE;
                    end else if (poll_to) begin
                        state <= S_RES;
                    end
                end
                S_DENSE: state <= S_POLLV;
                S_POLLV: begin
                    if (m_rdata[0] || poll_to) begin
                        state <= S_RES;
                    end
                end
                S_RES: begin
                    res_data <= res_err ? 16'h8000 : m_rdata[15:0];
                    res_pos  <= res_err ? 1'b0 : !m_rdata[15];
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready) begin
                        step_cnt <= 16'd0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_seq_driver.sv
// tb/tb_rnn_seq_driver.sv - self-checking bench for rnn_seq_driver with a behavioural RNN slave
`timescale 1ns/1ps
module tb_rnn_seq_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        emb_write;
    logic [5:0]  emb_tok;
    logic [1:0]  emb_idx;
    logic [15:0] emb_data;
    logic        emb_drop;
    logic        tok_valid;
    logic        tok_ready;
    logic [5:0]  tok_data;
    logic        tok_last;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_pos;
    logic        res_err;
    logic        busy;

    rnn_seq_driver #(.TOK_BITS(6), .EMB_BITS(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .emb_write(emb_write), .emb_tok(emb_tok), .emb_idx(emb_idx), .emb_data(emb_data),
        .emb_drop(emb_drop),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data), .tok_last(tok_last),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_pos(res_pos),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  tok;
        logic        last;
        logic        drop;
        int          s_after;
        int          v_after;
        logic [31:0] rword;
        int          exp_rd1;
        int          exp_rd0;
        logic [15:0] exp_res;
        logic        exp_pos;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_errors = 0;

    // slave model controls and bus monitor counters
    int          s_after = 0;
    int          v_after = 0;
    logic [31:0] r_word  = 32'd0;
    int cyc = 0;
    int n_rd1, n_rd0, n_rd7, n_wr1, n_wr0, n_wr7, n_strobe, drop_cnt, proto_err;
    int wr0_cyc, rd1_first_cyc;
    logic [31:0] wr1_log [4];
    int          wr1_cyc [4];
    logic [15:0] shadow [0:255];

    // Slave read data; counters already include the current read (counted on negedge).
    always_comb begin
        m_rdata = 32'd0;
        if (m_read) begin
            case (m_addr)
                3'd1:    m_rdata = (n_rd1 > s_after) ? 32'd1 : 32'd0;
                3'd0:    m_rdata = (n_rd0 > v_after) ? 32'd1 : 32'd0;
                3'd7:    m_rdata = r_word;
                default: m_rdata = 32'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (emb_drop) drop_cnt++;
        if (m_read && m_write) proto_err++;
        if (!m_read && !m_write && (m_addr != 3'd0 || m_wdata != 32'd0)) proto_err++;
        if (m_read || m_write) n_strobe++;
        if (m_write && m_addr == 3'd1) begin
            if (n_wr1 < 4) begin
                wr1_log[n_wr1] = m_wdata;
                wr1_cyc[n_wr1] = cyc;
            end
            n_wr1++;
        end
        if (m_write && m_addr == 3'd0) begin
            if (m_wdata != 32'd0) proto_err++;
            wr0_cyc = cyc;
            n_wr0++;
        end
        if (m_write && m_addr == 3'd7) n_wr7++;
        if (m_read && m_addr == 3'd1) begin
            if (n_rd1 == 0) rd1_first_cyc = cyc;
            n_rd1++;
        end
        if (m_read && m_addr == 3'd0) n_rd0++;
        if (m_read && m_addr == 3'd7) n_rd7++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_rd1 = 0; n_rd0 = 0; n_rd7 = 0; n_wr1 = 0; n_wr0 = 0; n_wr7 = 0;
        n_strobe = 0; drop_cnt = 0; wr0_cyc = -1; rd1_first_cyc = -1;
    endtask

    task automatic emb_wr(input logic [5:0] t, input logic [1:0] i, input logic [15:0] d);
        emb_write = 1'b1; emb_tok = t; emb_idx = i; emb_data = d;
        step();
        emb_write = 1'b0;
        shadow[{t, i}] = d;
    endtask

    task automatic send_tok(input logic [5:0] t, input logic l);
        for (int i = 0; i < 50 && !tok_ready; i++) step();
        check("tok_ready_before_send", {31'd0, tok_ready}, 32'd1);
        tok_valid = 1'b1; tok_data = t; tok_last = l;
        step();
        tok_valid = 1'b0; tok_last = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int   snap;
        logic stable;
        clear_counts();
        s_after = v.s_after; v_after = v.v_after; r_word = v.rword;
        send_tok(v.tok, v.last);
        if (v.drop) begin
            for (int i = 0; i < 50 && n_rd1 < 1; i++) step();
            emb_write = 1'b1; emb_tok = v.tok; emb_idx = 2'd0; emb_data = 16'hBEEF;
            step();
            emb_write = 1'b0;
            for (int i = 0; i < 3; i++) step();
            check($sformatf("v%0d_drop_pulses", n), drop_cnt, 32'd1);
        end
        for (int i = 0; i < 300; i++) begin
            if (v.last ? res_valid : (tok_ready && n_rd1 > 0)) break;
            step();
        end
        check($sformatf("v%0d_done", n), {31'd0, v.last ? res_valid : tok_ready}, 32'd1);
        check($sformatf("v%0d_wr1_count", n), n_wr1, 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d_load%0d_data", n, k), wr1_log[k],
                  {8'h00, 8'(k), shadow[{v.tok, 2'(k)}]});
            check($sformatf("v%0d_load%0d_cycle", n, k), wr1_cyc[k], wr1_cyc[0] + k);
        end
        check($sformatf("v%0d_start_count", n), n_wr0, 32'd1);
        check($sformatf("v%0d_start_cycle", n), wr0_cyc, wr1_cyc[3] + 1);
        check($sformatf("v%0d_first_poll_cycle", n), rd1_first_cyc, wr0_cyc + 1);
        check($sformatf("v%0d_rd1_count", n), n_rd1, v.exp_rd1);
        if (v.last) begin
            check($sformatf("v%0d_wr7_count", n), n_wr7, 32'd1);
            check($sformatf("v%0d_rd0_count", n), n_rd0, v.exp_rd0);
            check($sformatf("v%0d_rd7_count", n), n_rd7, 32'd1);
            check($sformatf("v%0d_res_data", n), res_data, v.exp_res);
            check($sformatf("v%0d_res_pos", n), res_pos, v.exp_pos);
            check($sformatf("v%0d_res_err", n), res_err, 32'd0);
            check($sformatf("v%0d_busy_out", n), busy, 32'd1);
            snap = n_strobe;
            stable = 1'b1;
            res_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (res_data !== v.exp_res || !res_valid || tok_ready) stable = 1'b0;
            end
            check($sformatf("v%0d_backpressure_stable", n), stable, 32'd1);
            check($sformatf("v%0d_backpressure_strobes", n), n_strobe, snap);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            check($sformatf("v%0d_after_res_busy", n), busy, 32'd0);
            check($sformatf("v%0d_after_res_valid", n), res_valid, 32'd0);
            check($sformatf("v%0d_after_res_ready", n), tok_ready, 32'd1);
        end else begin
            check($sformatf("v%0d_mid_busy", n), busy, 32'd1);
            check($sformatf("v%0d_mid_ready", n), tok_ready, 32'd1);
            check($sformatf("v%0d_mid_res_valid", n), res_valid, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; emb_write = 1'b0; emb_tok = '0; emb_idx = '0; emb_data = '0;
        tok_valid = 1'b0; tok_data = '0; tok_last = 1'b0; res_ready = 1'b0;
        proto_err = 0;
        clear_counts();

        //        tok    last  drop  s_aft v_aft rword          rd1 rd0 res       pos
        vecs[0] = '{6'd3,  1'b0, 1'b1, 5,    0,    32'h0,         6,  0,  16'h0000, 1'b0};
        vecs[1] = '{6'd5,  1'b1, 1'b0, 0,    2,    32'hFFFFFF80,  1,  3,  16'hFF80, 1'b0};
        vecs[2] = '{6'd0,  1'b1, 1'b0, 2,    0,    32'h00000123,  3,  1,  16'h0123, 1'b1};
        vecs[3] = '{6'd63, 1'b1, 1'b0, 1,    1,    32'h12340000,  2,  2,  16'h0000, 1'b1};
        vecs[4] = '{6'd3,  1'b1, 1'b0, 0,    0,    32'h00007FFF,  1,  1,  16'h7FFF, 1'b1};

        step();
        step();
        check("rst_ctrl_outs", {22'd0, m_read, m_write, m_addr, res_valid, res_err, res_pos, busy, tok_ready},
              32'd0);
        check("rst_emb_drop", emb_drop, 32'd0);
        check("rst_wdata", m_wdata, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_tok_ready", tok_ready, 32'd1);
        check("idle_busy", busy, 32'd0);

        emb_wr(6'd3, 2'd0, 16'h0100); emb_wr(6'd3, 2'd1, 16'h0000);
        emb_wr(6'd3, 2'd2, 16'hFF00); emb_wr(6'd3, 2'd3, 16'h0080);
        emb_wr(6'd5, 2'd0, 16'h1111); emb_wr(6'd5, 2'd1, 16'h2222);
        emb_wr(6'd5, 2'd2, 16'h3333); emb_wr(6'd5, 2'd3, 16'h4444);
        emb_wr(6'd0, 2'd0, 16'hFFFF); emb_wr(6'd0, 2'd1, 16'h8000);
        emb_wr(6'd0, 2'd2, 16'h7FFF); emb_wr(6'd0, 2'd3, 16'h0001);
        emb_wr(6'd63, 2'd0, 16'hABCD); emb_wr(6'd63, 2'd1, 16'h0000);
        emb_wr(6'd63, 2'd2, 16'h0000); emb_wr(6'd63, 2'd3, 16'hDCBA);
        step();
        check("idle_write_no_drop", drop_cnt, 32'd0);

        for (int n = 0; n < 5; n++) run_vec(n, vecs[n]);
        check("row3_elem0_literal", wr1_log[0], 32'h00000100);

        // reset in the middle of step polling
        clear_counts();
        s_after = 100000;
        send_tok(6'd0, 1'b0);
        for (int i = 0; i < 50 && n_rd1 < 2; i++) step();
        check("rst_mid_in_polls", {31'd0, m_read && m_addr == 3'd1}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {22'd0, m_read, m_write, m_addr, res_valid, res_err, res_pos, busy, tok_ready},
              32'd0);
        check("rst_mid_wdata", m_wdata, 32'd0);
        snap_and_release();

`ifdef POLL_TIMEOUT_EN
        clear_counts();
        s_after = 100000;
        r_word = 32'h00001234;
        send_tok(6'd5, 1'b0);
        for (int i = 0; i < 100 && !res_valid; i++) step();
        check("to_res_valid", res_valid, 32'd1);
        check("to_rd1_count", n_rd1, 32'd16);
        check("to_rd7_count", n_rd7, 32'd1);
        check("to_res_err", res_err, 32'd1);
        check("to_res_data", res_data, 32'h8000);
        check("to_res_pos", res_pos, 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("to_err_cleared", res_err, 32'd0);
        check("to_busy", busy, 32'd0);
`endif

        check("bus_protocol", proto_err, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic snap_and_release();
        int snap;
        snap = n_strobe;
        step(); step(); step();
        check("rst_mid_no_strobes", n_strobe, snap);
        s_after = 0;
        rst_n = 1'b1;
        step();
        step();
        check("rst_mid_tok_ready", tok_ready, 32'd1);
        check("rst_mid_busy", busy, 32'd0);
        check("rst_mid_after_strobes", n_strobe, snap);
    endtask

endmodule
